// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the mm:ss countdown timer
// Holds the controller state encoding, the 6-bit time-field type, the field
// limits and a clamp helper used when loading a preset.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } timer_state_t;

    typedef logic [5:0] time_field_t;

    localparam time_field_t SEC_MAX = 6'd59;
    localparam time_field_t MIN_MAX = 6'd59;

    function automatic time_field_t clamp_field(input time_field_t v, input time_field_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// rtl/timer_ctrl_if.sv - control/status bundle between button logic, timer and display
// Signals:
//   SCYCLE            CLOCK cycles per tick
//   START/STOP/CLEAR  single-cycle command pulses
//   LOAD_MIN/LOAD_SEC preset sampled on START from IDLE
//   MIN/SEC           remaining time
//   STATE             IDLE=0 RUN=1 PAUSE=2 ALARM=3
//   ALARM/DONE        alarm level and RUN->ALARM pulse
// Modports: master drives commands and reads status; slave is the timer.
interface timer_ctrl_if
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [CNT_W-1:0] SCYCLE;
    logic             START;
    logic             STOP;
    logic             CLEAR;
    time_field_t      LOAD_MIN;
    time_field_t      LOAD_SEC;
    time_field_t      MIN;
    time_field_t      SEC;
    logic [1:0]       STATE;
    logic             ALARM;
    logic             DONE;

    modport master (
        output SCYCLE, START, STOP, CLEAR, LOAD_MIN, LOAD_SEC,
        input  MIN, SEC, STATE, ALARM, DONE
    );

    modport slave (
        input  SCYCLE, START, STOP, CLEAR, LOAD_MIN, LOAD_SEC,
        output MIN, SEC, STATE, ALARM, DONE
    );

endinterface

// File: rtl/timer_ctrl_tick_gen.sv
// rtl/timer_ctrl_tick_gen.sv - tick prescaler producing a one-cycle clock enable
// Ports:
//   CLOCK, NRESET  clock and asynchronous active-low reset
//   EN             count enable (count holds when low)
//   CLR            synchronous clear, wins over EN
//   SCYCLE         cycles per tick; 0 behaves as 1
//   TICK           high for one cycle every max(SCYCLE,1) enabled cycles
module tick_gen #(
    parameter int CNT_W = 32
) (
    input  logic             CLOCK,
    input  logic             NRESET,
    input  logic             EN,
    input  logic             CLR,
    input  logic [CNT_W-1:0] SCYCLE,
    output logic             TICK
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_cnt;

    always_comb begin
        last_cnt = (SCYCLE == '0) ? '0 : SCYCLE - CNT_W'(1);
        // >= rather than == so that shrinking SCYCLE below the current count
        // fires on the next enabled cycle instead of wrapping the counter.
        TICK     = EN && (cnt_q >= last_cnt);
        cnt_d    = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (TICK) begin
            cnt_d = '0;
        end else if (EN) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - mm:ss countdown controller with alarm
// Ports:
//   CLOCK, NRESET  clock and asynchronous active-low reset
//   bus            timer_ctrl_if.slave: commands, preset, SCYCLE in; MIN/SEC/STATE/ALARM/DONE out
// Parameters: ALARM_TICKS (ticks spent in ALARM, >=1), CNT_W (prescaler width).
// Optional: TIMER_CTRL_AUTORELOAD_EN stores the last clamped preset and
// restarts from it at the end of ALARM instead of returning to IDLE.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int ALARM_TICKS = 5,
    parameter int CNT_W       = 32
) (
    input  logic         CLOCK,
    input  logic         NRESET,
    timer_ctrl_if.slave  bus
);

    localparam int          AW         = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

    timer_state_t  state_q, state_d;
    time_field_t   min_q, min_d, sec_q, sec_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          done_q, done_d;
`ifdef TIMER_CTRL_AUTORELOAD_EN
    time_field_t   pre_min_q, pre_min_d, pre_sec_q, pre_sec_d;
`endif

    time_field_t load_min, load_sec;
    logic        start_go, preset_zero, at_last_sec, alarm_end;
    logic        presc_en, presc_clr, tick;

    // STOP outranks START in every state, so a simultaneous pair never starts.
    assign load_min    = clamp_field(bus.LOAD_MIN, MIN_MAX);
    assign load_sec    = clamp_field(bus.LOAD_SEC, SEC_MAX);
    assign start_go    = bus.START && !bus.STOP;
    assign preset_zero = (load_min == '0) && (load_sec == '0);
    assign at_last_sec = (min_q == '0) && (sec_q == 6'd1);
    assign alarm_end   = tick && (alarm_cnt_q == ALARM_LAST);

    // STOP gates the prescaler, which also suppresses a coincident tick.
    assign presc_en  = !bus.CLEAR &&
                       (((state_q == ST_RUN) && !bus.STOP) || (state_q == ST_ALARM));
    assign presc_clr = bus.CLEAR || (state_q == ST_IDLE);

    tick_gen #(.CNT_W(CNT_W)) u_tick_gen (
        .CLOCK  (CLOCK),
        .NRESET (NRESET),
        .EN     (presc_en),
        .CLR    (presc_clr),
        .SCYCLE (bus.SCYCLE),
        .TICK   (tick)
    );

    always_ff @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            state_q     <= ST_IDLE;
            min_q       <= '0;
            sec_q       <= '0;
            alarm_cnt_q <= '0;
            done_q      <= 1'b0;
`ifdef TIMER_CTRL_AUTORELOAD_EN
            pre_min_q   <= '0;
            pre_sec_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            alarm_cnt_q <= alarm_cnt_d;
            done_q      <= done_d;
`ifdef TIMER_CTRL_AUTORELOAD_EN
            pre_min_q   <= pre_min_d;
            pre_sec_q   <= pre_sec_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.CLEAR) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (start_go && !preset_zero) state_d = ST_RUN;
                ST_RUN: begin
                    if (bus.STOP)                state_d = ST_PAUSE;
                    else if (tick && at_last_sec) state_d = ST_ALARM;
                end
                ST_PAUSE: if (start_go) state_d = ST_RUN;
                ST_ALARM: begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
                    if (alarm_end) state_d = ST_RUN;
`else
                    if (alarm_end) state_d = ST_IDLE;
`endif
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        min_d       = min_q;
        sec_d       = sec_q;
        alarm_cnt_d = alarm_cnt_q;
        done_d      = 1'b0;
`ifdef TIMER_CTRL_AUTORELOAD_EN
        pre_min_d   = pre_min_q;
        pre_sec_d   = pre_sec_q;
`endif
        if (bus.CLEAR) begin
            min_d       = '0;
            sec_d       = '0;
            alarm_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_go && !preset_zero) begin
                        min_d = load_min;
                        sec_d = load_sec;
`ifdef TIMER_CTRL_AUTORELOAD_EN
                        pre_min_d = load_min;
                        pre_sec_d = load_sec;
`endif
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (sec_q != '0) begin
                            sec_d = sec_q - 6'd1;
                        end else begin
                            sec_d = SEC_MAX;
                            min_d = min_q - 6'd1;
                        end
                        if (at_last_sec) begin
                            done_d      = 1'b1;
                            alarm_cnt_d = '0;
                        end
                    end
                end
                ST_ALARM: begin
                    if (alarm_end) begin
                        alarm_cnt_d = '0;
`ifdef TIMER_CTRL_AUTORELOAD_EN
                        min_d = pre_min_q;
                        sec_d = pre_sec_q;
`endif
                    end else if (tick) begin
                        alarm_cnt_d = alarm_cnt_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.MIN   = min_q;
    assign bus.SEC   = sec_q;
    assign bus.STATE = state_q;
    assign bus.ALARM = (state_q == ST_ALARM);
    assign bus.DONE  = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - self-checking bench for timer_ctrl
module tb_timer_ctrl;

    localparam int AT = 5;

    logic CLOCK = 1'b0;
    logic NRESET;
    timer_ctrl_if #(.CNT_W(32)) bus ();

    timer_ctrl #(.ALARM_TICKS(AT), .CNT_W(32)) dut (
        .CLOCK  (CLOCK),
        .NRESET (NRESET),
        .bus    (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining time kept as total seconds, prescaler as a phase.
    int     m_state = 0;
    int     m_rem = 0;
    int     m_reload = 0;
    int     m_alarm_left = 0;
    longint m_phase = 0;
    bit     m_done = 0;

    function automatic int clampi(int v);
        return (v > 59) ? 59 : v;
    endfunction

    task automatic model_advance(longint eff, output bit fired);
        fired = (m_phase >= eff - 1);
        if (fired) m_phase = 0;
        else       m_phase = m_phase + 1;
    endtask

    task automatic model_step();
        longint eff;
        bit     fired;
        int     p;
        eff    = (bus.SCYCLE == 0) ? 1 : longint'(bus.SCYCLE);
        m_done = 0;
        if (bus.CLEAR) begin
            m_state = 0; m_rem = 0; m_phase = 0; m_alarm_left = 0;
        end else begin
            case (m_state)
                0: begin
                    m_phase = 0;
                    p = clampi(int'(bus.LOAD_MIN)) * 60 + clampi(int'(bus.LOAD_SEC));
                    if (bus.START && !bus.STOP && p != 0) begin
                        m_rem = p; m_reload = p; m_state = 1;
                    end
                end
                1: begin
                    if (bus.STOP) m_state = 2;
                    else begin
                        model_advance(eff, fired);
                        if (fired) begin
                            m_rem = m_rem - 1;
                            if (m_rem == 0) begin
                                m_state = 3; m_done = 1; m_alarm_left = AT;
                            end
                        end
                    end
                end
                2: if (bus.START && !bus.STOP) m_state = 1;
                default: begin
                    model_advance(eff, fired);
                    if (fired) begin
                        m_alarm_left = m_alarm_left - 1;
                        if (m_alarm_left == 0) begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
                            m_rem = m_reload; m_state = 1;
`else
                            m_state = 0;
`endif
                        end
                    end
                end
            endcase
        end
    endtask

    always @(posedge CLOCK or negedge NRESET) begin
        if (!NRESET) begin
            m_state = 0; m_rem = 0; m_phase = 0; m_alarm_left = 0; m_done = 0;
        end else begin
            model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLOCK);
            @(negedge CLOCK);
        end
    endtask

    task automatic pulse(input bit s, input bit p, input bit c);
        bus.START = s; bus.STOP = p; bus.CLEAR = c;
        cyc(1);
        bus.START = 0; bus.STOP = 0; bus.CLEAR = 0;
    endtask

    task automatic preset(input int mm, input int ss, input int scy);
        bus.LOAD_MIN = 6'(mm); bus.LOAD_SEC = 6'(ss); bus.SCYCLE = 32'(scy);
    endtask

    task automatic test_reset();
        NRESET = 0;
        cyc(2);
        if ({bus.STATE, bus.MIN, bus.SEC, bus.ALARM, bus.DONE} !== 16'd0) begin
            errors++; $display("FAIL reset_vals: got st=%0d %0d:%0d al=%0d dn=%0d exp all 0", bus.STATE, bus.MIN, bus.SEC, bus.ALARM, bus.DONE);
        end
        checks++;
        NRESET = 1;
        cyc(1);
        if ({bus.STATE, bus.MIN, bus.SEC} !== 14'd0) begin
            errors++; $display("FAIL reset_release: got st=%0d %0d:%0d exp st=0 0:0", bus.STATE, bus.MIN, bus.SEC);
        end
        checks++;
    endtask

    task automatic test_basic();
        pulse(0, 0, 1);
        preset(0, 2, 4);
        pulse(1, 0, 0);
        if ({bus.STATE, bus.MIN, bus.SEC} !== {2'd1, 6'd0, 6'd2}) begin
            errors++; $display("FAIL basic_start: got st=%0d %0d:%0d exp st=1 0:2", bus.STATE, bus.MIN, bus.SEC);
        end
        checks++;
        cyc(3);
        if (bus.SEC !== 6'd2) begin
            errors++; $display("FAIL basic_pre_tick1: got sec=%0d exp 2", bus.SEC);
        end
        checks++;
        cyc(1);
        if ({bus.STATE, bus.SEC} !== {2'd1, 6'd1}) begin
            errors++; $display("FAIL basic_tick1: got st=%0d sec=%0d exp st=1 sec=1", bus.STATE, bus.SEC);
        end
        checks++;
        cyc(4);
        if ({bus.STATE, bus.MIN, bus.SEC, bus.ALARM, bus.DONE} !== {2'd3, 6'd0, 6'd0, 1'b1, 1'b1}) begin
            errors++; $display("FAIL basic_alarm_entry: got st=%0d %0d:%0d al=%0d dn=%0d exp st=3 0:0 al=1 dn=1", bus.STATE, bus.MIN, bus.SEC, bus.ALARM, bus.DONE);
        end
        checks++;
        cyc(1);
        if ({bus.ALARM, bus.DONE} !== 2'b10) begin
            errors++; $display("FAIL basic_done_pulse: got al=%0d dn=%0d exp al=1 dn=0", bus.ALARM, bus.DONE);
        end
        checks++;
        cyc(18);
        if ({bus.STATE, bus.ALARM} !== {2'd3, 1'b1}) begin
            errors++; $display("FAIL basic_alarm_hold: got st=%0d al=%0d exp st=3 al=1", bus.STATE, bus.ALARM);
        end
        checks++;
        cyc(1);
`ifdef TIMER_CTRL_AUTORELOAD_EN
        if ({bus.STATE, bus.MIN, bus.SEC, bus.ALARM} !== {2'd1, 6'd0, 6'd2, 1'b0}) begin
            errors++; $display("FAIL basic_alarm_end: got st=%0d %0d:%0d al=%0d exp st=1 0:2 al=0", bus.STATE, bus.MIN, bus.SEC, bus.ALARM);
        end
`else
        if ({bus.STATE, bus.MIN, bus.SEC, bus.ALARM} !== {2'd0, 6'd0, 6'd0, 1'b0}) begin
            errors++; $display("FAIL basic_alarm_end: got st=%0d %0d:%0d al=%0d exp st=0 0:0 al=0", bus.STATE, bus.MIN, bus.SEC, bus.ALARM);
        end
`endif
        checks++;
    endtask

    task automatic test_minute_rollover();
        pulse(0, 0, 1);
        preset(1, 0, 1);
        pulse(1, 0, 0);
        cyc(1);
        if ({bus.STATE, bus.MIN, bus.SEC} !== {2'd1, 6'd0, 6'd59}) begin
            errors++; $display("FAIL min_borrow: got st=%0d %0d:%0d exp st=1 0:59", bus.STATE, bus.MIN, bus.SEC);
        end
        checks++;
        cyc(58);
        if ({bus.STATE, bus.MIN, bus.SEC} !== {2'd1, 6'd0, 6'd1}) begin
            errors++; $display("FAIL min_tick59: got st=%0d %0d:%0d exp st=1 0:1", bus.STATE, bus.MIN, bus.SEC);
        end
        checks++;
        cyc(1);
        if ({bus.STATE, bus.DONE} !== {2'd3, 1'b1}) begin
            errors++; $display("FAIL min_tick60: got st=%0d dn=%0d exp st=3 dn=1", bus.STATE, bus.DONE);
        end
        checks++;
    endtask

    task automatic test_pause_resume();
        pulse(0, 0, 1);
        preset(0, 5, 10);
        pulse(1, 0, 0);
        cyc(3);
        pulse(0, 1, 0);
        if ({bus.STATE, bus.SEC} !== {2'd2, 6'd5}) begin
            errors++; $display("FAIL pause_enter: got st=%0d sec=%0d exp st=2 sec=5", bus.STATE, bus.SEC);
        end
        checks++;
        cyc(25);
        pulse(0, 1, 0);
        cyc(24);
        if ({bus.STATE, bus.SEC} !== {2'd2, 6'd5}) begin
            errors++; $display("FAIL pause_hold: got st=%0d sec=%0d exp st=2 sec=5", bus.STATE, bus.SEC);
        end
        checks++;
        pulse(1, 0, 0);
        cyc(6);
        if ({bus.STATE, bus.SEC} !== {2'd1, 6'd5}) begin
            errors++; $display("FAIL resume_pre: got st=%0d sec=%0d exp st=1 sec=5", bus.STATE, bus.SEC);
        end
        checks++;
        cyc(1);
        if (bus.SEC !== 6'd4) begin
            errors++; $display("FAIL resume_tick7: got sec=%0d exp 4", bus.SEC);
        end
        checks++;
        pulse(1, 0, 0);
        cyc(8);
        if ({bus.STATE, bus.SEC} !== {2'd1, 6'd4}) begin
            errors++; $display("FAIL start_in_run: got st=%0d sec=%0d exp st=1 sec=4", bus.STATE, bus.SEC);
        end
        checks++;
        pulse(0, 1, 0);
        if ({bus.STATE, bus.SEC} !== {2'd2, 6'd4}) begin
            errors++; $display("FAIL stop_beats_tick: got st=%0d sec=%0d exp st=2 sec=4", bus.STATE, bus.SEC);
        end
        checks++;
        pulse(1, 0, 0);
        cyc(1);
        if (bus.SEC !== 6'd3) begin
            errors++; $display("FAIL held_tick: got sec=%0d exp 3", bus.SEC);
        end
        checks++;
    endtask

    task automatic test_priority_and_clamp();
        pulse(0, 0, 1);
        preset(0, 5, 3);
        pulse(1, 0, 0);
        cyc(2);
        pulse(1, 1, 1);
        if ({bus.STATE, bus.MIN, bus.SEC} !== 14'd0) begin
            errors++; $display("FAIL all_cmds_clear: got st=%0d %0d:%0d exp st=0 0:0", bus.STATE, bus.MIN, bus.SEC);
        end
        checks++;
        preset(0, 0, 3);
        pulse(1, 0, 0);
        if ({bus.STATE, bus.MIN, bus.SEC} !== 14'd0) begin
            errors++; $display("FAIL zero_preset: got st=%0d %0d:%0d exp st=0 0:0", bus.STATE, bus.MIN, bus.SEC);
        end
        checks++;
        preset(0, 63, 3);
        pulse(1, 0, 0);
        if ({bus.STATE, bus.MIN, bus.SEC} !== {2'd1, 6'd0, 6'd59}) begin
            errors++; $display("FAIL clamp_sec: got st=%0d %0d:%0d exp st=1 0:59", bus.STATE, bus.MIN, bus.SEC);
        end
        checks++;
        pulse(0, 0, 1);
        preset(63, 10, 3);
        pulse(1, 0, 0);
        if ({bus.STATE, bus.MIN, bus.SEC} !== {2'd1, 6'd59, 6'd10}) begin
            errors++; $display("FAIL clamp_min: got st=%0d %0d:%0d exp st=1 59:10", bus.STATE, bus.MIN, bus.SEC);
        end
        checks++;
    endtask

    task automatic test_async_reset_and_scycle0();
        pulse(0, 0, 1);
        preset(0, 9, 2);
        pulse(1, 0, 0);
        cyc(3);
        #2 NRESET = 0;
        #1;
        if ({bus.STATE, bus.MIN, bus.SEC, bus.ALARM, bus.DONE} !== 16'd0) begin
            errors++; $display("FAIL async_reset: got st=%0d %0d:%0d al=%0d dn=%0d exp all 0", bus.STATE, bus.MIN, bus.SEC, bus.ALARM, bus.DONE);
        end
        checks++;
        @(negedge CLOCK);
        NRESET = 1;
        cyc(1);
        if ({bus.STATE, bus.SEC} !== 8'd0) begin
            errors++; $display("FAIL async_release: got st=%0d sec=%0d exp st=0 sec=0", bus.STATE, bus.SEC);
        end
        checks++;
        preset(0, 3, 0);
        pulse(1, 0, 0);
        cyc(1);
        if ({bus.STATE, bus.SEC} !== {2'd1, 6'd2}) begin
            errors++; $display("FAIL scycle0_t1: got st=%0d sec=%0d exp st=1 sec=2", bus.STATE, bus.SEC);
        end
        checks++;
        cyc(2);
        if ({bus.STATE, bus.DONE} !== {2'd3, 1'b1}) begin
            errors++; $display("FAIL scycle0_alarm: got st=%0d dn=%0d exp st=3 dn=1", bus.STATE, bus.DONE);
        end
        checks++;
    endtask

`ifdef TIMER_CTRL_AUTORELOAD_EN
    task automatic test_autoreload();
        pulse(0, 0, 1);
        preset(0, 3, 2);
        pulse(1, 0, 0);
        cyc(6);
        if (bus.STATE !== 2'd3) begin
            errors++; $display("FAIL reload_alarm: got st=%0d exp 3", bus.STATE);
        end
        checks++;
        cyc(10);
        if ({bus.STATE, bus.MIN, bus.SEC} !== {2'd1, 6'd0, 6'd3}) begin
            errors++; $display("FAIL reload_run: got st=%0d %0d:%0d exp st=1 0:3", bus.STATE, bus.MIN, bus.SEC);
        end
        checks++;
        pulse(0, 0, 1);
        if ({bus.STATE, bus.SEC} !== 8'd0) begin
            errors++; $display("FAIL reload_clear: got st=%0d sec=%0d exp st=0 sec=0", bus.STATE, bus.SEC);
        end
        checks++;
    endtask
`endif

    task automatic test_random();
        logic [15:0] exp_v;
        logic [15:0] got_v;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.SCYCLE = 32'($urandom_range(0, 6));
            bus.START    = ($urandom_range(0, 9) == 0);
            bus.STOP     = ($urandom_range(0, 19) == 0);
            bus.CLEAR    = ($urandom_range(0, 149) == 0);
            bus.LOAD_MIN = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 1));
            bus.LOAD_SEC = 6'($urandom_range(0, 63));
            cyc(1);
            exp_v = {2'(m_state), 6'(m_rem / 60), 6'(m_rem % 60), (m_state == 3), m_done};
            got_v = {bus.STATE, bus.MIN, bus.SEC, bus.ALARM, bus.DONE};
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d: got st=%0d %0d:%0d al=%0d dn=%0d exp st=%0d %0d:%0d al=%0d dn=%0d",
                         i, bus.STATE, bus.MIN, bus.SEC, bus.ALARM, bus.DONE,
                         m_state, m_rem / 60, m_rem % 60, (m_state == 3), m_done);
            end
            checks++;
        end
        bus.START = 0; bus.STOP = 0; bus.CLEAR = 0;
    endtask

    initial begin
        bus.START = 0; bus.STOP = 0; bus.CLEAR = 0;
        bus.LOAD_MIN = 0; bus.LOAD_SEC = 0; bus.SCYCLE = 32'd4;
        test_reset();
        test_basic();
        test_minute_rollover();
        test_pause_resume();
        test_priority_and_clamp();
        test_async_reset_and_scycle0();
`ifdef TIMER_CTRL_AUTORELOAD_EN
        test_autoreload();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
